// File: rtl/cdc_pulse_stretch_multi_if.sv
// Bundle of per-channel event inputs and conditioned outputs for cdc_pulse_stretch_multi.
// The master side drives events and overflow clears; the slave side is the conditioner.
interface cdc_pulse_stretch_multi_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] signal_in_fast;
  logic [WIDTH-1:0] ovf_clr;
  logic [WIDTH-1:0] signal_out_fast;
  logic [WIDTH-1:0] busy;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] overflow;

  modport master (
    output signal_in_fast,
    output ovf_clr,
    input  signal_out_fast,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  signal_in_fast,
    input  ovf_clr,
    output signal_out_fast,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/cdc_pulse_stretch_multi.sv
// Per-channel rising-edge to fixed-width pulse stretcher with low guard, one-deep event queue
// and sticky overflow; outputs come straight from flops so they can cross to a slower domain.
module cdc_pulse_stretch_multi #(
  parameter int WIDTH   = 8,
  parameter int STRETCH = 4,
  parameter int GAP     = 4
) (
  input  logic                    fast_clk,
  input  logic                    reset,
  cdc_pulse_stretch_multi_if.slave bus
);

  localparam int MAX_CNT = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] C_STRETCH = CW'(STRETCH - 1);
  localparam logic [CW-1:0] C_GAP     = CW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  if (STRETCH < 1) begin : g_bad_stretch
    $error("cdc_pulse_stretch_multi: STRETCH must be >= 1");
  end
  if (GAP < 1) begin : g_bad_gap
    $error("cdc_pulse_stretch_multi: GAP must be >= 1");
  end

  logic [WIDTH-1:0] r_in_prev;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] w_busy;
  logic [WIDTH-1:0] w_pend;
  logic [WIDTH-1:0] w_ovf;

  // History resets to all-ones so an input already high when reset lifts is not an event.
  // NOTE: sequential state uses non-blocking assignments and a synchronous reset branch
  // so every flop updates from pre-edge values, independent of block ordering.
  always_ff @(posedge fast_clk) begin
    if (reset) r_in_prev <= '1;
    else       r_in_prev <= bus.signal_in_fast;
  end

  assign w_edge = bus.signal_in_fast & ~r_in_prev;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_pend, w_pend_nxt;
    logic          r_ovf, w_ovf_nxt, w_ovf_set;
    logic          r_out, r_busy;

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      w_ovf_set   = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            // Event accepted in the last guard cycle launches one cycle late.
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = C_STRETCH;
            w_pend_nxt  = 1'b0;
            w_ovf_set   = w_edge[i];
          end else if (w_edge[i]) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = C_STRETCH;
          end
        end
        S_HIGH: begin
          if (r_cnt == '0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = C_GAP;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
          if (w_edge[i]) begin
            if (r_pend) w_ovf_set  = 1'b1;
            else        w_pend_nxt = 1'b1;
          end
        end
        S_GAP: begin
          if ((r_cnt == '0) && r_pend) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = C_STRETCH;
            w_pend_nxt  = 1'b0;
            w_ovf_set   = w_edge[i];
          end else begin
            if (r_cnt == '0) w_state_nxt = S_IDLE;
            else             w_cnt_nxt   = r_cnt - CW'(1);
            if (w_edge[i]) begin
              if (r_pend) w_ovf_set  = 1'b1;
              else        w_pend_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
      // A new drop in the same cycle as a clear keeps the flag set.
      w_ovf_nxt = w_ovf_set | (r_ovf & ~bus.ovf_clr[i]);
    end

    always_ff @(posedge fast_clk) begin
      if (reset) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_pend  <= 1'b0;
        r_ovf   <= 1'b0;
        r_out   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pend  <= w_pend_nxt;
        r_ovf   <= w_ovf_nxt;
        r_out   <= (w_state_nxt == S_HIGH);
        r_busy  <= (w_state_nxt != S_IDLE);
      end
    end

    assign w_out[i]  = r_out;
    assign w_busy[i] = r_busy;
    assign w_pend[i] = r_pend;
    assign w_ovf[i]  = r_ovf;
  end

  assign bus.signal_out_fast = w_out;
  assign bus.busy            = w_busy;
  assign bus.pending         = w_pend;
  assign bus.overflow        = w_ovf;

endmodule

// File: tb/tb_cdc_pulse_stretch_multi.sv
// Directed bench for cdc_pulse_stretch_multi (WIDTH=8, STRETCH=4, GAP=4).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cdc_pulse_stretch_multi;
  localparam int W = 8;

  logic fast_clk = 1'b0;
  logic reset;

  always #5 fast_clk = ~fast_clk;

  cdc_pulse_stretch_multi_if #(.WIDTH(W)) bus ();

  cdc_pulse_stretch_multi #(
    .WIDTH  (W),
    .STRETCH(4),
    .GAP    (4)
  ) dut (
    .fast_clk(fast_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge fast_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] e_out, e_busy, e_pend, e_ovf;

    // 1: reset with all inputs held high; no event until low then high
    reset              = 1'b1;
    bus.signal_in_fast = 8'hFF;
    bus.ovf_clr        = 8'h00;
    step(2);
    check("rst_out",  bus.signal_out_fast, 8'h00);
    check("rst_busy", bus.busy,            8'h00);
    check("rst_pend", bus.pending,         8'h00);
    check("rst_ovf",  bus.overflow,        8'h00);
    reset = 1'b0;
    step(3);
    check("held_out",  bus.signal_out_fast, 8'h00);
    check("held_busy", bus.busy,            8'h00);
    bus.signal_in_fast = 8'h00;
    step();
    check("low_out", bus.signal_out_fast, 8'h00);
    bus.signal_in_fast = 8'h01;
    step();
    check("rise_out",  bus.signal_out_fast, 8'h01);
    check("rise_busy", bus.busy,            8'h01);
    bus.signal_in_fast = 8'h00;
    step(8);
    check("t1_end_busy", bus.busy,            8'h00);
    check("t1_end_out",  bus.signal_out_fast, 8'h00);

    // 2: single-cycle pulse on ch1
    for (int j = 0; j <= 8; j++) begin
      bus.signal_in_fast = (j == 0) ? 8'h02 : 8'h00;
      step();
      e_out  = (j <= 3) ? 8'h02 : 8'h00;
      e_busy = (j <= 7) ? 8'h02 : 8'h00;
      check($sformatf("t2_out_j%0d", j),  bus.signal_out_fast, e_out);
      check($sformatf("t2_busy_j%0d", j), bus.busy,            e_busy);
    end

    // 3: second ch1 edge 2 cycles later is queued and launches right after the guard
    for (int j = 0; j <= 16; j++) begin
      bus.signal_in_fast = (j == 0 || j == 2) ? 8'h02 : 8'h00;
      step();
      e_out  = (j <= 3 || (j >= 8 && j <= 11)) ? 8'h02 : 8'h00;
      e_busy = (j <= 15) ? 8'h02 : 8'h00;
      e_pend = (j >= 2 && j <= 7) ? 8'h02 : 8'h00;
      check($sformatf("t3_out_j%0d", j),  bus.signal_out_fast, e_out);
      check($sformatf("t3_busy_j%0d", j), bus.busy,            e_busy);
      check($sformatf("t3_pend_j%0d", j), bus.pending,         e_pend);
      check($sformatf("t3_ovf_j%0d", j),  bus.overflow,        8'h00);
    end

    // 4: third ch3 edge overflows; clear with a concurrent drop keeps it; clear alone drops it
    for (int j = 0; j <= 16; j++) begin
      bus.signal_in_fast = (j == 0 || j == 2 || j == 4 || j == 6) ? 8'h08 : 8'h00;
      bus.ovf_clr        = (j == 6 || j == 9) ? 8'h08 : 8'h00;
      step();
      e_out  = (j <= 3 || (j >= 8 && j <= 11)) ? 8'h08 : 8'h00;
      e_busy = (j <= 15) ? 8'h08 : 8'h00;
      e_pend = (j >= 2 && j <= 7) ? 8'h08 : 8'h00;
      e_ovf  = (j >= 4 && j <= 8) ? 8'h08 : 8'h00;
      check($sformatf("t4_out_j%0d", j),  bus.signal_out_fast, e_out);
      check($sformatf("t4_busy_j%0d", j), bus.busy,            e_busy);
      check($sformatf("t4_pend_j%0d", j), bus.pending,         e_pend);
      check($sformatf("t4_ovf_j%0d", j),  bus.overflow,        e_ovf);
    end
    bus.ovf_clr = 8'h00;

    // 5: 02 -> 0E -> 00 -> 02 at 6-cycle spacing; ch2/ch3 independent, ch1 queued once
    for (int j = 0; j <= 26; j++) begin
      case (j)
        0:       bus.signal_in_fast = 8'h02;
        6:       bus.signal_in_fast = 8'h0E;
        18:      bus.signal_in_fast = 8'h02;
        default: bus.signal_in_fast = 8'h00;
      endcase
      step();
      e_out  = 8'h00;
      e_busy = 8'h00;
      e_pend = 8'h00;
      if (j <= 3 || (j >= 8 && j <= 11) || (j >= 18 && j <= 21)) e_out[1] = 1'b1;
      if (j >= 6 && j <= 9)                                      e_out[3:2] = 2'b11;
      if (j <= 15 || (j >= 18 && j <= 25))                       e_busy[1] = 1'b1;
      if (j >= 6 && j <= 13)                                     e_busy[3:2] = 2'b11;
      if (j == 6 || j == 7)                                      e_pend[1] = 1'b1;
      check($sformatf("t5_out_j%0d", j),  bus.signal_out_fast, e_out);
      check($sformatf("t5_busy_j%0d", j), bus.busy,            e_busy);
      check($sformatf("t5_pend_j%0d", j), bus.pending,         e_pend);
      check($sformatf("t5_ovf_j%0d", j),  bus.overflow,        8'h00);
    end

    // 6: reset while ch4 is HIGH with an event queued, then a fresh edge
    bus.signal_in_fast = 8'h10;
    step();
    bus.signal_in_fast = 8'h00;
    step();
    bus.signal_in_fast = 8'h10;
    step();
    check("t6_pre_out",  bus.signal_out_fast, 8'h10);
    check("t6_pre_pend", bus.pending,         8'h10);
    bus.signal_in_fast = 8'h00;
    reset              = 1'b1;
    step();
    check("t6_rst_out",  bus.signal_out_fast, 8'h00);
    check("t6_rst_busy", bus.busy,            8'h00);
    check("t6_rst_pend", bus.pending,         8'h00);
    check("t6_rst_ovf",  bus.overflow,        8'h00);
    reset = 1'b0;
    step();
    check("t6_idle_out", bus.signal_out_fast, 8'h00);
    bus.signal_in_fast = 8'h10;
    step();
    check("t6_new_out",  bus.signal_out_fast, 8'h10);
    check("t6_new_busy", bus.busy,            8'h10);
    bus.signal_in_fast = 8'h00;
    step(3);
    check("t6_last_high", bus.signal_out_fast, 8'h10);
    step();
    check("t6_gap_out", bus.signal_out_fast, 8'h00);
    step(4);
    check("t6_end_busy", bus.busy, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
